button_conditioner: RTL
=======================

Name: button_conditioner

Overview:
- Receive-side conditioner for the button bus driven by the host-side fake FPGA model.
- Synchronizes each raw button bit, debounces it, and produces a stable level plus one-cycle press and release pulses for user logic.
- Sits between the fake FPGA button outputs and the design logic that drives the LEDs.
- Removes host-induced glitches and timing races from the asynchronously updated button bus.

Parameters:
- WIDTH, 8, number of button channels.
- SYNC_STAGES, 2, flip-flop stages in each input synchronizer; must be at least 1.
- DEBOUNCE_CYCLES, 4, consecutive synchronized samples differing from the stable level that are required to accept a change; must be at least 1.

Ports:
- clk  input  1  single design clock.
- rst_n  input  1  synchronous, active-low reset.
- buttons_in  input  WIDTH  raw asynchronous buttons from the fake FPGA.
- buttons_out  output  WIDTH  debounced stable button level.
- press  output  WIDTH  one-cycle pulse per bit on an accepted 0->1 change.
- release  output  WIDTH  one-cycle pulse per bit on an accepted 1->0 change.
- any_change  output  1  OR of press and release, same cycle.

Behaviour:
- Reset: single clock, synchronous active-low reset sampled on the rising edge of clk. When rst_n=0 at a rising edge, all of the following clear to 0:
  - synchronizer flops
  - debounce counters
  - buttons_out, press, release, any_change
- Reset mid-operation discards any partial count. No pulse is emitted for a change that was in progress.
- Synchronizer: buttons_in[i] passes through SYNC_STAGES flops. The last stage is the sample s[i].
- Per-bit counter: width $clog2(DEBOUNCE_CYCLES+1). On each edge:
  - s[i]==buttons_out[i]: cnt clears to 0.
  - s[i]!=buttons_out[i] and cnt < DEBOUNCE_CYCLES-1: cnt increments.
  - s[i]!=buttons_out[i] and cnt == DEBOUNCE_CYCLES-1: commit. buttons_out[i] takes s[i], cnt clears to 0, and press[i] or release[i] goes high on the same edge.
- Pulses:
  - press, release and any_change are registered and high for exactly one cycle per commit.
  - press and release are never both high for the same bit.
  - Bits are independent. Several bits committing on the same edge assert several pulse bits together.
- Latency:
  - A clean step on buttons_in, applied before edge k, appears on buttons_out after edge k+SYNC_STAGES+DEBOUNCE_CYCLES-1.
  - That is SYNC_STAGES+DEBOUNCE_CYCLES edges, counting the capture edge.
- Glitches:
  - A deviation shorter than DEBOUNCE_CYCLES synchronized samples produces no output change and no pulse.
  - A sample equal to the stable level restarts the count. Counts do not accumulate across bounces.
- Held at reset: a bit held high while rst_n=0 is treated as a normal 0->1 change after reset release. It produces a press at the normal latency.
- DEBOUNCE_CYCLES=1: the first differing sample commits immediately and cnt stays 0.
- Counter never exceeds DEBOUNCE_CYCLES-1. No wrap-around is possible.

Decomposition:
- Shared package fake_fpga_pkg holds:
  - NUM_BUTTONS=8 and NUM_LEDS=8, used as the WIDTH default.
  - a localparam function for the counter width, $clog2(DEBOUNCE_CYCLES+1).
- One sub-module, button_debounce_bit, holds the single-channel synchronizer, counter, stable flop and pulse flops.
- button_conditioner instantiates button_debounce_bit WIDTH times in a generate loop and ORs the pulses into any_change.

Test Plan:
All scenarios use WIDTH=8, SYNC_STAGES=2, DEBOUNCE_CYCLES=4.
1. Reset: rst_n=0 for 3 cycles with buttons_in=8'hFF, then release -> all outputs 0 during reset. After release, buttons_out=8'hFF 6 edges later, with press=8'hFF and any_change=1 for exactly 1 cycle.
2. Clean press then release: buttons_in[3] goes 0->1 before edge k, then 1->0 twenty cycles later.
   - buttons_out[3]=1 after edge k+5, with press=8'h08 for one cycle.
   - Later release=8'h08 for one cycle.
   - No other bits toggle.
3. Glitch rejection: buttons_in[0] high for 3 cycles, then low -> buttons_out stays 8'h00, and press/release/any_change stay 0 throughout.
4. Bounce restart: buttons_in[5] pattern 1,1,1,0,1,1,1,1 (one value per cycle) -> buttons_out[5]=1 only after the final run of 4 ones has passed the synchronizer. Exactly one press=8'h20 is emitted.
5. Simultaneous events: buttons_in steps 8'h00->8'hA5 at once -> single commit edge with press=8'hA5 and release=8'h00. Then a step to 8'h5A gives, on one edge, press=8'h5A, release=8'hA5 and any_change=1.
6. Reset mid-count: buttons_in[7] goes high and rst_n is pulsed low for 1 cycle after 2 differing samples, input still held high -> no press before reset. After reset release, press=8'h80 occurs 6 edges later and never twice.

Source files
------------

// File: rtl/fake_fpga_pkg.sv
// fake_fpga_pkg
// Shared constants for the fake-FPGA button/LED path and a helper that sizes
// the per-channel debounce counter.
//   NUM_BUTTONS   : width of the button bus driven by the host model
//   NUM_LEDS      : width of the LED bus read back by the host model
//   counter_width : bits needed to hold a debounce count of 0..DEBOUNCE_CYCLES
package fake_fpga_pkg;

  localparam int NUM_BUTTONS = 8;
  localparam int NUM_LEDS    = 8;

  // Counter width for a debounce threshold. Sized for 0..DEBOUNCE_CYCLES so a
  // threshold of 1 still gets a 1-bit counter.
  function automatic int counter_width(input int debounce_cycles);
    return $clog2(debounce_cycles + 1);
  endfunction

endpackage

// File: rtl/button_debounce_bit.sv
// button_debounce_bit
// One button channel: SYNC_STAGES-deep synchronizer, debounce counter, stable
// level flop and registered press/release pulses.
//   clk           : design clock
//   rst_n         : synchronous active-low reset
//   button_in     : raw asynchronous button bit
//   level         : debounced stable level
//   press         : one-cycle pulse on an accepted 0->1 change
//   release_pulse : one-cycle pulse on an accepted 1->0 change
module button_debounce_bit
  import fake_fpga_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic button_in,
  output logic level,
  output logic press,
  output logic release_pulse
);

  localparam int CW = counter_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic [SYNC_STAGES-1:0] sync;
  logic [CW-1:0]          cnt;
  logic                   sample;

  assign sample = sync[SYNC_STAGES-1];

  // Input synchronizer: stage 0 captures the raw bit, the last stage is the sample.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync <= '0;
    end else begin
      sync[0] <= button_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync[i] <= sync[i-1];
      end
    end
  end

  // Debounce: count consecutive samples that differ from the stable level and
  // commit on the DEBOUNCE_CYCLES-th one. Any agreeing sample restarts the count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt           <= '0;
      level         <= 1'b0;
      press         <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      press         <= 1'b0;
      release_pulse <= 1'b0;
      if (sample == level) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        cnt           <= '0;
        level         <= sample;
        press         <= sample;
        release_pulse <= ~sample;
      end else begin
        cnt <= cnt + ONE;
      end
    end
  end

endmodule

// File: rtl/button_conditioner.sv
// button_conditioner
// Receive-side conditioner for the host-driven button bus. Each bit is
// synchronized and debounced independently; the top collects the per-bit
// stable levels and pulses.
//   clk           : design clock
//   rst_n         : synchronous active-low reset
//   buttons_in    : raw asynchronous buttons [WIDTH]
//   buttons_out   : debounced stable levels [WIDTH]
//   press         : one-cycle pulses on accepted 0->1 changes [WIDTH]
//   release_pulse : one-cycle pulses on accepted 1->0 changes [WIDTH]
//                   ("release" itself is a reserved SystemVerilog keyword)
//   any_change    : OR of press and release_pulse, same cycle
module button_conditioner
  import fake_fpga_pkg::*;
#(
  parameter int WIDTH           = NUM_BUTTONS,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] buttons_in,
  output logic [WIDTH-1:0] buttons_out,
  output logic [WIDTH-1:0] press,
  output logic [WIDTH-1:0] release_pulse,
  output logic             any_change
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    button_debounce_bit #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_bit (
      .clk           (clk),
      .rst_n         (rst_n),
      .button_in     (buttons_in[i]),
      .level         (buttons_out[i]),
      .press         (press[i]),
      .release_pulse (release_pulse[i])
    );
  end

  // Pulses are already registered, so this OR lines up with them cycle-for-cycle.
  assign any_change = |(press | release_pulse);

endmodule
